// File: rtl/writeback_pipe_pkg.sv
// Shared CPU definitions for the EX/ME/WB writeback pipeline: stage entry
// layout, register constants and the "does this entry write a register" test.
package writeback_pipe_pkg;

    localparam int         XLEN     = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       is_load;
        logic [4:0] wa;
    } stage_t;

    localparam int     STAGE_W     = $bits(stage_t);
    localparam stage_t STAGE_EMPTY = '0;

    // Register 0 is hardwired, so an entry targeting it never produces a write.
    function automatic logic writes_reg(input stage_t s);
        return s.valid && s.we && (s.wa != REG_ZERO);
    endfunction

endpackage

// File: rtl/writeback_pipe_wb_stage_reg.sv
// One pipeline stage holding an entry plus its 32-bit data word; it loads on
// advance and can be forced to a bubble instead of the incoming entry.
import writeback_pipe_pkg::*;

module wb_stage_reg (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_adv,
    input  logic               i_bubble,
    input  logic [STAGE_W-1:0] i_entry,
    input  logic [XLEN-1:0]    i_data,
    output logic [STAGE_W-1:0] o_entry,
    output logic [XLEN-1:0]    o_data
);

    logic [STAGE_W-1:0] r_entry;
    logic [XLEN-1:0]    r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_entry <= i_bubble ? STAGE_EMPTY : i_entry;
            r_data  <= i_data;
        end
    end

    assign o_entry = r_entry;
    assign o_data  = r_data;

endmodule

// File: rtl/writeback_pipe.sv
// EX/ME/WB tail of the CPU pipeline: forwarding bus, register-file write port,
// load-use hazard detection and retired-instruction counting.
import writeback_pipe_pkg::*;

module writeback_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_we,
    input  logic        id_is_load,
    input  logic [4:0]  id_wa,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_rdata,
    input  logic        stall_in,
    input  logic        flush,
    output logic        we_ex,
    output logic        we_me,
    output logic        we_wb,
    output logic [4:0]  wa_ex,
    output logic [4:0]  wa_me,
    output logic [4:0]  wa_wb,
    output logic [31:0] wd_ex,
    output logic [31:0] wd_me,
    output logic [31:0] wd_wb,
    output logic        commit_we,
    output logic [4:0]  commit_addr,
    output logic [31:0] commit_data,
    output logic        load_use_stall,
    output logic [31:0] instret
);

    stage_t            r_ex;
    logic [XLEN-1:0]   r_instret;
    stage_t            w_id;
    stage_t            w_me;
    stage_t            w_wb;
    logic [XLEN-1:0]   w_me_data;
    logic [XLEN-1:0]   w_wb_data;
    logic              w_adv;
    logic              w_ex_bubble;
    logic              w_lu_hazard;

    assign w_adv = !stall_in;
    assign w_id  = '{valid: id_valid, we: id_we, is_load: id_is_load, wa: id_wa};

    // A load in EX has no data yet, so a dependent instruction in ID must wait one cycle.
    assign w_lu_hazard = id_valid && writes_reg(r_ex) && r_ex.is_load &&
                         ((r_ex.wa == id_rs1) || (r_ex.wa == id_rs2));
    assign w_ex_bubble = flush || w_lu_hazard;

    // ID -> EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex <= STAGE_EMPTY;
        end else if (w_adv) begin
            r_ex <= w_ex_bubble ? STAGE_EMPTY : w_id;
        end
    end

    // EX -> ME
    wb_stage_reg u_me (
        .clk      (clk),
        .rst      (rst),
        .i_adv    (w_adv),
        .i_bubble (1'b0),
        .i_entry  (r_ex),
        .i_data   (ex_result),
        .o_entry  (w_me),
        .o_data   (w_me_data)
    );

    // ME -> WB; loads resolve to memory data here so WB always holds the final value
    wb_stage_reg u_wb (
        .clk      (clk),
        .rst      (rst),
        .i_adv    (w_adv),
        .i_bubble (1'b0),
        .i_entry  (w_me),
        .i_data   (wd_me),
        .o_entry  (w_wb),
        .o_data   (w_wb_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (w_adv && w_wb.valid) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign we_ex = writes_reg(r_ex) && !r_ex.is_load;
    assign we_me = writes_reg(w_me);
    assign we_wb = writes_reg(w_wb);
    assign wa_ex = r_ex.wa;
    assign wa_me = w_me.wa;
    assign wa_wb = w_wb.wa;
    assign wd_ex = ex_result;
    assign wd_me = w_me.is_load ? mem_rdata : w_me_data;
    assign wd_wb = w_wb_data;

    assign commit_we      = we_wb;
    assign commit_addr    = wa_wb;
    assign commit_data    = wd_wb;
    assign load_use_stall = w_lu_hazard;
    assign instret        = r_instret;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe: hand-computed vectors per feature, each
// scenario task checking outputs inline against expected constants.
module tb_writeback_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_we, id_is_load;
    logic [4:0]  id_wa, id_rs1, id_rs2;
    logic [31:0] ex_result, mem_rdata;
    logic        stall_in, flush;
    logic        we_ex, we_me, we_wb;
    logic [4:0]  wa_ex, wa_me, wa_wb;
    logic [31:0] wd_ex, wd_me, wd_wb;
    logic        commit_we;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic        load_use_stall;
    logic [31:0] instret;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    writeback_pipe dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_we(id_we), .id_is_load(id_is_load),
        .id_wa(id_wa), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_result(ex_result), .mem_rdata(mem_rdata),
        .stall_in(stall_in), .flush(flush),
        .we_ex(we_ex), .we_me(we_me), .we_wb(we_wb),
        .wa_ex(wa_ex), .wa_me(wa_me), .wa_wb(wa_wb),
        .wd_ex(wd_ex), .wd_me(wd_me), .wd_wb(wd_wb),
        .commit_we(commit_we), .commit_addr(commit_addr), .commit_data(commit_data),
        .load_use_stall(load_use_stall), .instret(instret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic we, input logic ld,
                          input logic [4:0] wa, input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid = v; id_we = we; id_is_load = ld; id_wa = wa; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic test_reset();
        rst = 1'b0; ex_result = 32'hA5A5_0001; mem_rdata = 32'hDEAD_BEEF;
        step(); step();
        if (we_ex !== 1'b0) begin n_miss++; $display("FAIL reset_we_ex got %0h exp 0", we_ex); end n_vec++;
        if (we_me !== 1'b0) begin n_miss++; $display("FAIL reset_we_me got %0h exp 0", we_me); end n_vec++;
        if (we_wb !== 1'b0) begin n_miss++; $display("FAIL reset_we_wb got %0h exp 0", we_wb); end n_vec++;
        if (commit_we !== 1'b0) begin n_miss++; $display("FAIL reset_commit_we got %0h exp 0", commit_we); end n_vec++;
        if (load_use_stall !== 1'b0) begin n_miss++; $display("FAIL reset_lus got %0h exp 0", load_use_stall); end n_vec++;
        if (wd_ex !== 32'hA5A5_0001) begin n_miss++; $display("FAIL reset_wd_ex got %0h exp a5a50001", wd_ex); end n_vec++;
        if (wd_me !== 32'h0) begin n_miss++; $display("FAIL reset_wd_me got %0h exp 0", wd_me); end n_vec++;
        if (wd_wb !== 32'h0) begin n_miss++; $display("FAIL reset_wd_wb got %0h exp 0", wd_wb); end n_vec++;
        if (wa_me !== 5'd0) begin n_miss++; $display("FAIL reset_wa_me got %0h exp 0", wa_me); end n_vec++;
        if (instret !== 32'h0) begin n_miss++; $display("FAIL reset_instret got %0h exp 0", instret); end n_vec++;
        rst = 1'b1;
    endtask

    task automatic test_alu_chain();
        set_id(1, 1, 0, 5'd5, 5'd1, 5'd2);
        step();
        id_valid = 0; ex_result = 32'h1234; #1;
        if (we_ex !== 1'b1) begin n_miss++; $display("FAIL alu_we_ex got %0h exp 1", we_ex); end n_vec++;
        if (wa_ex !== 5'd5) begin n_miss++; $display("FAIL alu_wa_ex got %0d exp 5", wa_ex); end n_vec++;
        if (wd_ex !== 32'h1234) begin n_miss++; $display("FAIL alu_wd_ex got %0h exp 1234", wd_ex); end n_vec++;
        step();
        ex_result = 32'h0; #1;
        if (we_me !== 1'b1) begin n_miss++; $display("FAIL alu_we_me got %0h exp 1", we_me); end n_vec++;
        if (wa_me !== 5'd5) begin n_miss++; $display("FAIL alu_wa_me got %0d exp 5", wa_me); end n_vec++;
        if (wd_me !== 32'h1234) begin n_miss++; $display("FAIL alu_wd_me got %0h exp 1234", wd_me); end n_vec++;
        step();
        if (commit_we !== 1'b1) begin n_miss++; $display("FAIL alu_commit_we got %0h exp 1", commit_we); end n_vec++;
        if (commit_addr !== 5'd5) begin n_miss++; $display("FAIL alu_commit_addr got %0d exp 5", commit_addr); end n_vec++;
        if (commit_data !== 32'h1234) begin n_miss++; $display("FAIL alu_commit_data got %0h exp 1234", commit_data); end n_vec++;
        if (instret !== 32'd0) begin n_miss++; $display("FAIL alu_instret_pre got %0d exp 0", instret); end n_vec++;
        step();
        if (instret !== 32'd1) begin n_miss++; $display("FAIL alu_instret got %0d exp 1", instret); end n_vec++;
        if (commit_we !== 1'b0) begin n_miss++; $display("FAIL alu_commit_after got %0h exp 0", commit_we); end n_vec++;
    endtask

    task automatic test_load_use();
        set_id(1, 1, 1, 5'd7, 5'd0, 5'd0);
        step();
        set_id(0, 1, 0, 5'd9, 5'd7, 5'd0); #1;
        if (load_use_stall !== 1'b0) begin n_miss++; $display("FAIL lu_idle got %0h exp 0", load_use_stall); end n_vec++;
        id_valid = 1; #1;
        if (load_use_stall !== 1'b1) begin n_miss++; $display("FAIL lu_rs1 got %0h exp 1", load_use_stall); end n_vec++;
        if (we_ex !== 1'b0) begin n_miss++; $display("FAIL lu_we_ex_load got %0h exp 0", we_ex); end n_vec++;
        if (wa_ex !== 5'd7) begin n_miss++; $display("FAIL lu_wa_ex got %0d exp 7", wa_ex); end n_vec++;
        id_rs1 = 5'd3; id_rs2 = 5'd7; #1;
        if (load_use_stall !== 1'b1) begin n_miss++; $display("FAIL lu_rs2 got %0h exp 1", load_use_stall); end n_vec++;
        id_rs2 = 5'd6; #1;
        if (load_use_stall !== 1'b0) begin n_miss++; $display("FAIL lu_nomatch got %0h exp 0", load_use_stall); end n_vec++;
        id_rs1 = 5'd7; id_rs2 = 5'd0; #1;
        step();
        mem_rdata = 32'hCAFE; #1;
        if (load_use_stall !== 1'b0) begin n_miss++; $display("FAIL lu_one_cycle got %0h exp 0", load_use_stall); end n_vec++;
        if (we_ex !== 1'b0) begin n_miss++; $display("FAIL lu_bubble_we_ex got %0h exp 0", we_ex); end n_vec++;
        if (we_me !== 1'b1) begin n_miss++; $display("FAIL lu_we_me got %0h exp 1", we_me); end n_vec++;
        if (wa_me !== 5'd7) begin n_miss++; $display("FAIL lu_wa_me got %0d exp 7", wa_me); end n_vec++;
        if (wd_me !== 32'hCAFE) begin n_miss++; $display("FAIL lu_wd_me got %0h exp cafe", wd_me); end n_vec++;
        step();
        id_valid = 0; ex_result = 32'h55; #1;
        if (we_ex !== 1'b1) begin n_miss++; $display("FAIL lu_dep_we_ex got %0h exp 1", we_ex); end n_vec++;
        if (wa_ex !== 5'd9) begin n_miss++; $display("FAIL lu_dep_wa_ex got %0d exp 9", wa_ex); end n_vec++;
        if (we_me !== 1'b0) begin n_miss++; $display("FAIL lu_bubble_we_me got %0h exp 0", we_me); end n_vec++;
        if (commit_addr !== 5'd7) begin n_miss++; $display("FAIL lu_commit_addr got %0d exp 7", commit_addr); end n_vec++;
        if (commit_data !== 32'hCAFE) begin n_miss++; $display("FAIL lu_commit_data got %0h exp cafe", commit_data); end n_vec++;
        step();
        if (instret !== 32'd2) begin n_miss++; $display("FAIL lu_instret2 got %0d exp 2", instret); end n_vec++;
        if (commit_we !== 1'b0) begin n_miss++; $display("FAIL lu_wb_bubble got %0h exp 0", commit_we); end n_vec++;
        if (wd_me !== 32'h55) begin n_miss++; $display("FAIL lu_dep_wd_me got %0h exp 55", wd_me); end n_vec++;
        step();
        if (commit_addr !== 5'd9) begin n_miss++; $display("FAIL lu_dep_commit_addr got %0d exp 9", commit_addr); end n_vec++;
        if (commit_data !== 32'h55) begin n_miss++; $display("FAIL lu_dep_commit_data got %0h exp 55", commit_data); end n_vec++;
        step();
        if (instret !== 32'd3) begin n_miss++; $display("FAIL lu_instret3 got %0d exp 3", instret); end n_vec++;
    endtask

    task automatic test_reg0();
        set_id(1, 1, 0, 5'd0, 5'd0, 5'd0);
        step();
        id_valid = 0; #1;
        if (we_ex !== 1'b0) begin n_miss++; $display("FAIL r0_we_ex got %0h exp 0", we_ex); end n_vec++;
        step();
        if (we_me !== 1'b0) begin n_miss++; $display("FAIL r0_we_me got %0h exp 0", we_me); end n_vec++;
        step();
        if (we_wb !== 1'b0) begin n_miss++; $display("FAIL r0_we_wb got %0h exp 0", we_wb); end n_vec++;
        if (commit_we !== 1'b0) begin n_miss++; $display("FAIL r0_commit_we got %0h exp 0", commit_we); end n_vec++;
        step();
        if (instret !== 32'd4) begin n_miss++; $display("FAIL r0_instret got %0d exp 4", instret); end n_vec++;
    endtask

    task automatic test_stall_flush();
        set_id(1, 1, 0, 5'd3, 5'd0, 5'd0);
        step();
        ex_result = 32'h33; id_wa = 5'd4;
        step();
        id_valid = 0; ex_result = 32'h44; stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (we_ex !== 1'b1 || wa_ex !== 5'd4) begin n_miss++; $display("FAIL stall_ex got we=%0h wa=%0d exp we=1 wa=4", we_ex, wa_ex); end n_vec++;
            if (we_me !== 1'b1 || wa_me !== 5'd3) begin n_miss++; $display("FAIL stall_me got we=%0h wa=%0d exp we=1 wa=3", we_me, wa_me); end n_vec++;
            if (wd_me !== 32'h33) begin n_miss++; $display("FAIL stall_wd_me got %0h exp 33", wd_me); end n_vec++;
            if (commit_we !== 1'b0) begin n_miss++; $display("FAIL stall_commit got %0h exp 0", commit_we); end n_vec++;
            if (instret !== 32'd4) begin n_miss++; $display("FAIL stall_instret got %0d exp 4", instret); end n_vec++;
        end
        stall_in = 0; set_id(1, 1, 0, 5'd6, 5'd0, 5'd0); flush = 1;
        step();
        flush = 0; id_valid = 0; #1;
        if (we_ex !== 1'b0) begin n_miss++; $display("FAIL flush_we_ex got %0h exp 0", we_ex); end n_vec++;
        if (wa_me !== 5'd4 || wd_me !== 32'h44) begin n_miss++; $display("FAIL flush_me got wa=%0d wd=%0h exp wa=4 wd=44", wa_me, wd_me); end n_vec++;
        if (commit_we !== 1'b1 || commit_addr !== 5'd3 || commit_data !== 32'h33) begin n_miss++; $display("FAIL flush_commit3 got we=%0h a=%0d d=%0h exp 1/3/33", commit_we, commit_addr, commit_data); end n_vec++;
        step();
        if (instret !== 32'd5 || commit_addr !== 5'd4 || commit_data !== 32'h44) begin n_miss++; $display("FAIL flush_commit4 got n=%0d a=%0d d=%0h exp 5/4/44", instret, commit_addr, commit_data); end n_vec++;
        step();
        if (commit_we !== 1'b0 || instret !== 32'd6) begin n_miss++; $display("FAIL flush_gone1 got we=%0h n=%0d exp 0/6", commit_we, instret); end n_vec++;
        step();
        if (commit_we !== 1'b0 || instret !== 32'd6) begin n_miss++; $display("FAIL flush_gone2 got we=%0h n=%0d exp 0/6", commit_we, instret); end n_vec++;
        // flush and load-use together: bubble inserted, dependent entry dropped
        set_id(1, 1, 1, 5'd8, 5'd0, 5'd0);
        step();
        set_id(1, 1, 0, 5'd13, 5'd8, 5'd0); flush = 1; stall_in = 1; #1;
        if (load_use_stall !== 1'b1) begin n_miss++; $display("FAIL prec_lus_stalled got %0h exp 1", load_use_stall); end n_vec++;
        stall_in = 0; #1;
        if (load_use_stall !== 1'b1) begin n_miss++; $display("FAIL prec_lus got %0h exp 1", load_use_stall); end n_vec++;
        step();
        flush = 0; id_valid = 0; #1;
        if (we_ex !== 1'b0 || wa_ex !== 5'd0) begin n_miss++; $display("FAIL prec_bubble got we=%0h wa=%0d exp 0/0", we_ex, wa_ex); end n_vec++;
        if (we_me !== 1'b1 || wa_me !== 5'd8) begin n_miss++; $display("FAIL prec_me got we=%0h wa=%0d exp 1/8", we_me, wa_me); end n_vec++;
        step();
        if (commit_we !== 1'b1 || commit_addr !== 5'd8) begin n_miss++; $display("FAIL prec_commit8 got we=%0h a=%0d exp 1/8", commit_we, commit_addr); end n_vec++;
        step();
        if (commit_we !== 1'b0 || instret !== 32'd7) begin n_miss++; $display("FAIL prec_after1 got we=%0h n=%0d exp 0/7", commit_we, instret); end n_vec++;
        step();
        if (commit_we !== 1'b0 || instret !== 32'd7) begin n_miss++; $display("FAIL prec_after2 got we=%0h n=%0d exp 0/7", commit_we, instret); end n_vec++;
    endtask

    task automatic test_reset_inflight();
        set_id(1, 1, 0, 5'd10, 5'd0, 5'd0);
        step(); id_wa = 5'd11;
        step(); id_wa = 5'd12;
        step(); id_valid = 0; #1;
        if (commit_we !== 1'b1 || commit_addr !== 5'd10) begin n_miss++; $display("FAIL rf_pre got we=%0h a=%0d exp 1/10", commit_we, commit_addr); end n_vec++;
        #2; rst = 0; #1;
        if (commit_we !== 1'b0) begin n_miss++; $display("FAIL rf_commit_we got %0h exp 0", commit_we); end n_vec++;
        if (we_ex !== 1'b0 || we_me !== 1'b0 || we_wb !== 1'b0) begin n_miss++; $display("FAIL rf_we got %0h%0h%0h exp 000", we_ex, we_me, we_wb); end n_vec++;
        if (wa_wb !== 5'd0 || wd_wb !== 32'h0) begin n_miss++; $display("FAIL rf_wb got a=%0d d=%0h exp 0/0", wa_wb, wd_wb); end n_vec++;
        if (instret !== 32'd0) begin n_miss++; $display("FAIL rf_instret got %0d exp 0", instret); end n_vec++;
        step(); step();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (commit_we !== 1'b0 || instret !== 32'd0) begin n_miss++; $display("FAIL rf_after got we=%0h n=%0d exp 0/0", commit_we, instret); end n_vec++;
        end
    endtask

    task automatic test_wrap();
        stall_in = 1; #1;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        step();
        if (instret !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL wrap_preload got %0h exp ffffffff", instret); end n_vec++;
        set_id(1, 1, 0, 5'd20, 5'd0, 5'd0); stall_in = 0;
        step(); id_valid = 0;
        step(); step();
        if (commit_we !== 1'b1 || commit_addr !== 5'd20 || instret !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL wrap_commit got we=%0h a=%0d n=%0h exp 1/20/ffffffff", commit_we, commit_addr, instret); end n_vec++;
        step();
        if (instret !== 32'h0) begin n_miss++; $display("FAIL wrap_instret got %0h exp 0", instret); end n_vec++;
    endtask

    initial begin
        set_id(0, 0, 0, 5'd0, 5'd0, 5'd0);
        stall_in = 0; flush = 0; rst = 0;
        ex_result = 32'h0; mem_rdata = 32'h0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_reg0();
        test_stall_flush();
        test_reset_inflight();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have clk, input, 1, clock; all state updates on the rising edge.
REQ-002 SHALL have rst, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have id_valid/id_we/id_is_load, input, 1 each: the decoded instruction is real / writes a register / is a load.
REQ-004 SHALL have id_wa, input, 5, destination register of the decoded instruction; id_rs1/id_rs2, input, 5 each, its source registers.
REQ-005 SHALL have ex_result, input, 32, ALU result of the current EX entry (combinational); mem_rdata, input, 32, load data of the current ME entry (combinational).
REQ-006 SHALL have stall_in, input, 1, global freeze; flush, input, 1, kill the incoming ID entry.
REQ-007 SHALL have we_ex/we_me/we_wb, output, 1 each; wa_ex/wa_me/wa_wb, output, 5 each; wd_ex/wd_me/wd_wb, output, 32 each: the forwarding bus to the register file.
REQ-008 SHALL have commit_we, output, 1; commit_addr, output, 5; commit_data, output, 32: the register-file write port.
REQ-009 SHALL have load_use_stall, output, 1, hold ID this cycle; instret, output, 32, retired-instruction count.

Function
REQ-010 SHALL hold three stage registers, EX, ME and WB; each holds {valid, we, is_load, wa} and ME/WB also hold data[31:0].
REQ-011 SHALL advance all stages on a rising edge when stall_in=0; with stall_in=1 no stage, counter or output register changes.
REQ-012 SHALL load EX from ID when advancing, load_use_stall=0 and flush=0; when flush=1 or load_use_stall=1, EX SHALL load a bubble (valid=0).
REQ-013 SHALL have ME capture data=ex_result on advance; WB SHALL capture data=wd_me.
REQ-014 SHALL drive wd_ex=ex_result; wd_me=mem_rdata when the ME entry is a load, else ME data; wd_wb=WB data.
REQ-015 SHALL drive we_x=valid&we&(wa!=0) for ME and WB; we_ex SHALL additionally require is_load=0, since load data is not available in EX.
REQ-016 SHALL drive load_use_stall=1 when id_valid, the EX entry is valid&we&is_load, EX wa!=0, and (EX wa==id_rs1 or EX wa==id_rs2); otherwise 0.
REQ-017 SHALL make load_use_stall independent of stall_in and flush (combinational from state and ID inputs).
REQ-018 SHALL drive commit_we=we_wb, commit_addr=wa_wb, commit_data=wd_wb; writes to register 0 never commit.
REQ-019 SHALL increment instret by 1, modulo 2^32 (FFFF_FFFF wraps to 0), on each advancing edge where WB is valid.
REQ-020 SHALL use the following latency: an ID entry accepted at edge k is in EX during cycle k+1, ME during k+2 and WB during k+3, and commits at edge k+4.
REQ-021 SHALL sample flush only on advancing edges; upstream holds flush until stall_in=0.
REQ-022 SHALL give flush precedence when flush and load_use_stall are both asserted: a bubble is inserted either way, and the ID entry is discarded, not held.

Reset
REQ-023 SHALL, while rst=0, clear all stage valid bits, wa fields and data fields, and clear instret to 0.
REQ-024 SHALL hold all we_*, commit_we and load_use_stall at 0 during reset; wd_ex follows ex_result, and all other outputs are 0.
REQ-025 SHALL discard in-flight entries on reset mid-operation without committing them.

Structure
REQ-026 SHALL place the stage-entry typedef {valid, we, is_load, wa} and the constants REG_ZERO=5'd0, REG_RA=5'd31 and XLEN=32 in the shared CPU package.
REQ-027 SHALL instantiate one sub-module, wb_stage_reg: a stage entry plus data register with advance/bubble controls, used for ME and WB.

Verification
REQ-028 ALU chain: ID add wa=5, ex_result=0x1234 -> we_ex=1, wa_ex=5, wd_ex=0x1234 in cycle k+1; we_me=1 in k+2; commit_we=1, commit_addr=5, commit_data=0x1234 in k+3; instret=1 after that edge.
REQ-029 Load-use: load wa=7, then ID with rs1=7 -> load_use_stall=1 for exactly 1 cycle, one EX bubble, we_ex=0; next cycle we_me=1, wd_me=mem_rdata=0xCAFE.
REQ-030 Register-0 write: id_wa=0, id_we=1 -> we_ex, we_me, we_wb and commit_we remain 0 throughout, and instret still increments.
REQ-031 Stall and flush: stall_in=1 for 3 cycles mid-stream -> outputs and instret frozen; flush=1 on an advancing edge -> that ID entry never appears and never commits.
REQ-032 Reset and wrap: rst=0 with 3 entries in flight -> no commits, instret=0; instret preloaded to 0xFFFF_FFFF plus one retire -> 0.
